zbritesi_serial_16: RTL



---
 rtl/zbritesi_pkg.sv | 12 +
 rtl/zbritesi1b.sv | 13 +
 rtl/zbritesi_serial_16.sv | 116 +++++++++++
 3 files changed

// File: rtl/zbritesi_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package zbritesi_pkg;

  localparam int ZBR_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } zbr_state_t;

endpackage

// File: rtl/zbritesi1b.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module zbritesi1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/zbritesi_serial_16.sv
// Bit-serial A - B, one bit per clock, start/done handshake.
// Optional signed overflow flag under `ZBRITESI_SIGNED_FLAGS_EN.
module zbritesi_serial_16
  import zbritesi_pkg::*;
#(
  parameter int WIDTH = ZBR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             BorrowOut,
  output logic             busy,
  output logic             done
`ifdef ZBRITESI_SIGNED_FLAGS_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = $clog2(WIDTH);

  zbr_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] diff_sh;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d;
  logic             borrow_n;
  logic [WIDTH-1:0] diff_nx;
  logic             last;

`ifdef ZBRITESI_SIGNED_FLAGS_EN
  logic a_msb;
  logic b_msb;
`endif

  zbritesi1b u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (d),
    .bout (borrow_n)
  );

  // New bit enters at the MSB; on the last edge diff_nx is the full difference.
  assign diff_nx = {d, diff_sh};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      diff_sh   <= '0;
      cnt       <= '0;
      borrow    <= 1'b0;
      result    <= '0;
      BorrowOut <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ZBRITESI_SIGNED_FLAGS_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      Overflow  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= CALC;
            a_sh   <= A;
            b_sh   <= B;
            cnt    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b1;
`ifdef ZBRITESI_SIGNED_FLAGS_EN
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          diff_sh <= diff_nx[WIDTH-1:1];
          borrow  <= borrow_n;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            cnt       <= '0;
            result    <= diff_nx;
            BorrowOut <= borrow_n;
            busy      <= 1'b0;
            done      <= 1'b1;
`ifdef ZBRITESI_SIGNED_FLAGS_EN
            // d is the result MSB on this edge
            Overflow  <= (a_msb != b_msb) & (d != a_msb);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
